// File: rtl/lru_req_frontend_if.sv
// Handshake bundle for lru_req_frontend: upstream request stream, LRU port, downstream result stream.
// master = the front end itself, slave = the environment around it.
interface lru_req_frontend_if #(
    parameter int KW = 16,
    parameter int VW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [KW-1:0] in_key;
    logic [VW-1:0] in_value;

    logic          lru_enable;
    logic          lru_ready;
    logic [KW-1:0] lru_key;
    logic [VW-1:0] lru_value;
    logic          lru_done;
    logic          lru_hit;
    logic [VW-1:0] lru_value_out;
    logic          lru_crashed;

    logic          out_valid;
    logic          out_ready;
    logic [KW-1:0] out_key;
    logic          out_hit;
    logic [VW-1:0] out_value;

    modport master (
        input  in_valid, in_key, in_value,
        output in_ready,
        output lru_enable, lru_key, lru_value,
        input  lru_ready, lru_done, lru_hit, lru_value_out, lru_crashed,
        output out_valid, out_key, out_hit, out_value,
        input  out_ready
    );

    modport slave (
        output in_valid, in_key, in_value,
        input  in_ready,
        input  lru_enable, lru_key, lru_value,
        output lru_ready, lru_done, lru_hit, lru_value_out, lru_crashed,
        input  out_valid, out_key, out_hit, out_value,
        output out_ready
    );
endinterface

// File: rtl/lru_req_frontend.sv
// Request FIFO + single-outstanding issue FSM in front of the LRU cache; halts on LRU crash.
// Optional hit/miss statistics counters are enabled with `define LRU_FRONTEND_STATS_EN.
module lru_req_frontend #(
    parameter int KEY_WIDTH_IN_OCTETS  = 2,
    parameter int VALUE_WIDTH_IN_BITS  = 8,
    parameter int FIFO_DEPTH_IDX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    lru_req_frontend_if.master     bus,
    output logic                   error
`ifdef LRU_FRONTEND_STATS_EN
    ,
    output logic [15:0]            stat_hits,
    output logic [15:0]            stat_misses
`endif
);
    localparam int KW    = 8 * KEY_WIDTH_IN_OCTETS;
    localparam int VW    = VALUE_WIDTH_IN_BITS;
    localparam int IW    = FIFO_DEPTH_IDX_WIDTH;
    localparam int CW    = IW + 1;
    localparam int DEPTH = 1 << IW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [KW-1:0] key;
        logic [VW-1:0] value;
    } req_t;

    req_t          fifo_mem [DEPTH];
    logic [IW-1:0] wr_ptr;
    logic [IW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    state_t        state;
    state_t        state_next;
    req_t          hold;
    logic          res_hit;
    logic [VW-1:0] res_value;
    logic          error_q;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.in_valid && bus.in_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        pop        = 1'b0;
        if (bus.lru_crashed) begin
            state_next = S_HALT;
        end else begin
            case (state)
                S_IDLE:  if (!empty) begin
                             pop        = 1'b1;
                             state_next = S_ISSUE;
                         end
                S_ISSUE: if (bus.lru_ready) state_next = S_WAIT;
                S_WAIT:  if (bus.lru_done)  state_next = S_RESP;
                S_RESP:  if (bus.out_ready) state_next = S_IDLE;
                S_HALT:  state_next = S_HALT;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            hold      <= '0;
            res_hit   <= 1'b0;
            res_value <= '0;
            error_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + IW'(1);
            if (pop)  rd_ptr <= rd_ptr + IW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (pop) hold <= fifo_mem[rd_ptr];
            // Stray done strobes outside WAIT never touch the result registers.
            if (state == S_WAIT && bus.lru_done && !bus.lru_crashed) begin
                res_hit   <= bus.lru_hit;
                res_value <= bus.lru_hit ? bus.lru_value_out : hold.value;
            end
            if (bus.lru_crashed) error_q <= 1'b1;
        end
    end

    // NOTE: storage has no reset; occupancy and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{key: bus.in_key, value: bus.in_value};
    end

    // Every output is forced low while reset is held, independent of register contents.
    assign bus.in_ready   = reset && !full;
    assign bus.lru_enable = reset && (state == S_ISSUE);
    assign bus.lru_key    = reset ? hold.key   : '0;
    assign bus.lru_value  = reset ? hold.value : '0;
    assign bus.out_valid  = reset && (state == S_RESP);
    assign bus.out_key    = reset ? hold.key   : '0;
    assign bus.out_hit    = reset && res_hit;
    assign bus.out_value  = reset ? res_value  : '0;
    assign error          = reset && error_q;

`ifdef LRU_FRONTEND_STATS_EN
    logic [15:0] hits_q;
    logic [15:0] misses_q;
    logic        resp_done;

    assign resp_done = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (resp_done) begin
            if (res_hit && hits_q != 16'hFFFF)    hits_q   <= hits_q + 16'd1;
            if (!res_hit && misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
        end
    end

    assign stat_hits   = reset ? hits_q   : '0;
    assign stat_misses = reset ? misses_q : '0;
`endif
endmodule
